divider_pipe: RTL and testbench

- Next-generation pipelined integer divider for the softmax datapath, for example normalising exp() sums.
- Dividend width, divisor width and bits-per-stage (latency/area trade) are all parametrised.
- Adds a valid/ready handshake with full-pipeline backpressure, a per-transaction tag, a divide-by-zero flag and an optional signed mode.
- Sits between the exp accumulator and the output quantiser.

---
 rtl/divider_pkg.sv | 19 +
 rtl/divider_pipe_if.sv | 29 ++
 rtl/divider_stage.sv | 86 ++++++++
 rtl/divider_pipe.sv | 125 ++++++++++++
 tb/tb_divider_pipe.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared constants and helpers for the pipelined restoring divider.
package divider_pkg;

   localparam int DEF_N     = 40;
   localparam int DEF_M     = 32;
   localparam int DEF_B     = 4;
   localparam int DEF_TAG_W = 4;
   localparam int MAX_W     = 128;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Quotient reported for a zero divisor: n ones, right-aligned.
   function automatic logic [MAX_W-1:0] div_zero_quotient(input int n);
      return {MAX_W{1'b1}} >> (MAX_W - n);
   endfunction

endpackage

// File: rtl/divider_pipe_if.sv
// Operand/result handshake bundle of the pipelined divider.
interface divider_pipe_if #(
   parameter int N     = divider_pkg::DEF_N,
   parameter int M     = divider_pkg::DEF_M,
   parameter int TAG_W = divider_pkg::DEF_TAG_W
);
   logic             in_valid;
   logic             in_ready;
   logic             in_signed;
   logic [TAG_W-1:0] in_tag;
   logic [N-1:0]     dividend;
   logic [M-1:0]     divisor;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     quotient;
   logic [M-1:0]     remainder;
   logic             div_zero;
   logic [TAG_W-1:0] out_tag;

   modport slave (
      input  in_valid, in_signed, in_tag, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero, out_tag
   );

   modport master (
      output in_valid, in_signed, in_tag, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero, out_tag
   );
endinterface

// File: rtl/divider_stage.sv
// One registered restoring-division stage resolving B quotient bits MSB-first.
module divider_stage
   import divider_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int M     = DEF_M,
   parameter int B     = DEF_B,
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          prev_valid,
   input  logic [M-1:0]                  prev_rem,
   input  logic [ceil_div(N,B)*B-1:0]    prev_dvd,
   input  logic [M-1:0]                  prev_dsr,
   input  logic [ceil_div(N,B)*B-1:0]    prev_quo,
   input  logic [TAG_W-1:0]              prev_tag,
   input  logic                          prev_zero,
   input  logic                          prev_neg_q,
   input  logic                          prev_neg_r,
   output logic                          stage_valid,
   output logic [M-1:0]                  stage_rem,
   output logic [ceil_div(N,B)*B-1:0]    stage_dvd,
   output logic [M-1:0]                  stage_dsr,
   output logic [ceil_div(N,B)*B-1:0]    stage_quo,
   output logic [TAG_W-1:0]              stage_tag,
   output logic                          stage_zero,
   output logic                          stage_neg_q,
   output logic                          stage_neg_r
);

   localparam int W = ceil_div(N, B) * B;

   logic [M-1:0] rem_next;
   logic [W-1:0] dvd_next;
   logic [W-1:0] quo_next;
   logic [M:0]   trial;

   // NOTE: blocking assignments here are intentional: each loop pass feeds the
   // next within the same cycle, unrolling into a B-deep compare/subtract chain.
   always_comb begin
      rem_next = prev_rem;
      dvd_next = prev_dvd;
      quo_next = prev_quo;
      trial    = '0;
      for (int k = 0; k < B; k++) begin
         trial    = {rem_next, dvd_next[W-1]};
         dvd_next = dvd_next << 1;
         if (prev_zero || trial >= {1'b0, prev_dsr}) begin
            trial    = trial - {1'b0, prev_dsr};
            quo_next = {quo_next[W-2:0], 1'b1};
         end else begin
            quo_next = {quo_next[W-2:0], 1'b0};
         end
         rem_next = trial[M-1:0];
      end
   end

   // NOTE: datapath fields are cleared on reset as well, because the last
   // stage drives the block outputs directly and they must read zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid <= 1'b0;
         stage_rem   <= '0;
         stage_dvd   <= '0;
         stage_dsr   <= '0;
         stage_quo   <= '0;
         stage_tag   <= '0;
         stage_zero  <= 1'b0;
         stage_neg_q <= 1'b0;
         stage_neg_r <= 1'b0;
      end else if (en) begin
         stage_valid <= prev_valid;
         stage_rem   <= rem_next;
         stage_dvd   <= dvd_next;
         stage_dsr   <= prev_dsr;
         stage_quo   <= quo_next;
         stage_tag   <= prev_tag;
         stage_zero  <= prev_zero;
         stage_neg_q <= prev_neg_q;
         stage_neg_r <= prev_neg_r;
      end
   end

endmodule

// File: rtl/divider_pipe.sv
// Pipelined integer divider with valid/ready backpressure, tag and divide-by-zero flag.
// Define DIVIDER_SIGNED_EN to build the two's-complement mode selected by in_signed.
module divider_pipe
   import divider_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int M     = DEF_M,
   parameter int B     = DEF_B,
   parameter int TAG_W = DEF_TAG_W
) (
   input logic           clk,
   input logic           rst,
   divider_pipe_if.slave bus
);

   localparam int L = ceil_div(N, B);
   localparam int W = L * B;
   localparam logic [N-1:0] DIV0_Q = N'(div_zero_quotient(N));

   logic             valid_c [L+1];
   logic [M-1:0]     rem_c   [L+1];
   logic [W-1:0]     dvd_c   [L+1];
   logic [M-1:0]     dsr_c   [L+1];
   logic [W-1:0]     quo_c   [L+1];
   logic [TAG_W-1:0] tag_c   [L+1];
   logic             zero_c  [L+1];
   logic             neg_q_c [L+1];
   logic             neg_r_c [L+1];

   logic         stall;
   logic         advance;
   logic         dsr_zero;
   logic [N-1:0] dvd_mag;
   logic [M-1:0] dsr_mag;
   logic         neg_q_in;
   logic         neg_r_in;
   logic [N-1:0] quo_fin;
   logic [M-1:0] rem_fin;

   assign stall        = valid_c[L] & ~bus.out_ready;
   assign advance      = ~stall;
   assign bus.in_ready = ~stall & ~rst;
   assign dsr_zero     = (bus.divisor == '0);

`ifdef DIVIDER_SIGNED_EN
   // A zero divisor keeps the raw dividend so its low bits come back untouched.
   always_comb begin
      dvd_mag  = bus.dividend;
      dsr_mag  = bus.divisor;
      neg_q_in = 1'b0;
      neg_r_in = 1'b0;
      if (bus.in_signed && !dsr_zero) begin
         if (bus.dividend[N-1]) dvd_mag = -bus.dividend;
         if (bus.divisor[M-1])  dsr_mag = -bus.divisor;
         neg_q_in = bus.dividend[N-1] ^ bus.divisor[M-1];
         neg_r_in = bus.dividend[N-1];
      end
   end
`else
   assign dvd_mag  = bus.dividend;
   assign dsr_mag  = bus.divisor;
   assign neg_q_in = 1'b0;
   assign neg_r_in = 1'b0;
`endif

   assign valid_c[0] = bus.in_valid & bus.in_ready;
   assign rem_c[0]   = '0;
   assign dvd_c[0]   = W'(dvd_mag);
   assign dsr_c[0]   = dsr_mag;
   assign quo_c[0]   = '0;
   assign tag_c[0]   = bus.in_tag;
   assign zero_c[0]  = dsr_zero;
   assign neg_q_c[0] = neg_q_in;
   assign neg_r_c[0] = neg_r_in;

   for (genvar s = 0; s < L; s++) begin : g_stage
      divider_stage #(
         .N     (N),
         .M     (M),
         .B     (B),
         .TAG_W (TAG_W)
      ) u_stage (
         .clk         (clk),
         .rst         (rst),
         .en          (advance),
         .prev_valid  (valid_c[s]),
         .prev_rem    (rem_c[s]),
         .prev_dvd    (dvd_c[s]),
         .prev_dsr    (dsr_c[s]),
         .prev_quo    (quo_c[s]),
         .prev_tag    (tag_c[s]),
         .prev_zero   (zero_c[s]),
         .prev_neg_q  (neg_q_c[s]),
         .prev_neg_r  (neg_r_c[s]),
         .stage_valid (valid_c[s+1]),
         .stage_rem   (rem_c[s+1]),
         .stage_dvd   (dvd_c[s+1]),
         .stage_dsr   (dsr_c[s+1]),
         .stage_quo   (quo_c[s+1]),
         .stage_tag   (tag_c[s+1]),
         .stage_zero  (zero_c[s+1]),
         .stage_neg_q (neg_q_c[s+1]),
         .stage_neg_r (neg_r_c[s+1])
      );
   end

`ifdef DIVIDER_SIGNED_EN
   always_comb begin
      quo_fin = quo_c[L][N-1:0];
      rem_fin = rem_c[L];
      if (neg_q_c[L]) quo_fin = -quo_c[L][N-1:0];
      if (neg_r_c[L]) rem_fin = -rem_c[L];
   end
`else
   assign quo_fin = quo_c[L][N-1:0];
   assign rem_fin = rem_c[L];
`endif

   assign bus.out_valid = valid_c[L];
   assign bus.quotient  = zero_c[L] ? DIV0_Q : quo_fin;
   assign bus.remainder = rem_fin;
   assign bus.div_zero  = zero_c[L];
   assign bus.out_tag   = tag_c[L];

endmodule

// File: tb/tb_divider_pipe.sv
// Randomised and directed bench for divider_pipe against an arithmetic reference model.
module tb_divider_pipe;
   import divider_pkg::*;

   localparam int N     = 40;
   localparam int M     = 32;
   localparam int B     = 4;
   localparam int TAG_W = 4;
   localparam int L     = ceil_div(N, B);
   localparam logic [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

   typedef struct {
      logic [N-1:0]     q;
      logic [M-1:0]     r;
      logic             z;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   divider_pipe_if #(.N(N), .M(M), .TAG_W(TAG_W)) bus ();

   divider_pipe #(.N(N), .M(M), .B(B), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   pushes   = 0;
   int   pops     = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] a, input logic [M-1:0] d,
                                  input logic sgn, input logic [TAG_W-1:0] t);
      exp_t e;
      e.tag = t;
      e.z   = (d == '0);
      if (d == '0) begin
         e.q = '1;
         e.r = a[M-1:0];
      end
`ifdef DIVIDER_SIGNED_EN
      else if (sgn) begin
         longint sa, sd;
         sa  = longint'($signed(a));
         sd  = longint'($signed(d));
         e.q = N'(sa / sd);
         e.r = M'(sa % sd);
      end
`endif
      else begin
         e.q = N'(64'(a) / 64'(d));
         e.r = M'(64'(a) % 64'(d));
      end
      return e;
   endfunction

   // Scoreboard: record accepts, compare every presented result, pop on handshake.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 64'(bus.out_valid), 64'd0);
            end else begin
               check("quotient",  64'(bus.quotient),  64'(sb[0].q));
               check("remainder", 64'(bus.remainder), 64'(sb[0].r));
               check("div_zero",  64'(bus.div_zero),  64'(sb[0].z));
               check("out_tag",   64'(bus.out_tag),   64'(sb[0].tag));
               if (bus.out_ready) begin
                  void'(sb.pop_front());
                  pops++;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.dividend, bus.divisor, bus.in_signed, bus.in_tag));
            pushes++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] a, input logic [M-1:0] d,
                        input logic s, input logic [TAG_W-1:0] t);
      bus.in_valid  = 1'b1;
      bus.dividend  = a;
      bus.divisor   = d;
      bus.in_signed = s;
      bus.in_tag    = t;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic rand_op(output logic [N-1:0] a, output logic [M-1:0] d, output logic s);
      logic [31:0] x, y, z;
      int mode;
      x    = $urandom;
      y    = $urandom;
      z    = $urandom;
      mode = $urandom_range(0, 7);
      a    = {x[7:0], y};
      case (mode)
         0:       d = '0;
         1:       d = M'(z[3:0]) + 1;
         2:       begin a = N'(z[15:0]); d = y; end
         3:       begin a = '0; d = z; end
         default: d = z;
      endcase
`ifdef DIVIDER_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         tick();
         n++;
      end
      check({name, "_drained"}, 64'(sb.size()), 64'd0);
   endtask

   task automatic run_single(input string name, input logic [N-1:0] a, input logic [M-1:0] d,
                             input logic s, input logic [TAG_W-1:0] t,
                             input logic [N-1:0] eq, input logic [M-1:0] er, input logic ez);
      int n;
      drive(a, d, s, t);
      tick();
      idle();
      n = 1;
      while (!bus.out_valid && n < 4 * L) begin
         tick();
         n++;
      end
      check({name, "_latency"}, 64'(n), 64'(L));
      check({name, "_q"},   64'(bus.quotient),  64'(eq));
      check({name, "_r"},   64'(bus.remainder), 64'(er));
      check({name, "_z"},   64'(bus.div_zero),  64'(ez));
      check({name, "_tag"}, 64'(bus.out_tag),   64'(t));
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] a;
      logic [M-1:0] d;
      logic         s;
      int           pops0, pushes0;

      bus.in_valid  = 1'b0;
      bus.in_signed = 1'b0;
      bus.in_tag    = '0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.out_ready = 1'b1;
      rst           = 1'b1;

      repeat (3) tick();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_quotient",  64'(bus.quotient),  64'd0);
      check("rst_remainder", 64'(bus.remainder), 64'd0);
      check("rst_div_zero",  64'(bus.div_zero),  64'd0);
      check("rst_out_tag",   64'(bus.out_tag),   64'd0);
      check("rst_in_ready",  64'(bus.in_ready),  64'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      tick();

      // Directed cases.
      run_single("d29_5",  40'd29, 32'd5, 1'b0, 4'd3, 40'd5, 32'd4, 1'b0);
      run_single("div0",   40'h12_3456_789A, 32'd0, 1'b0, 4'd9,
                 40'hFF_FFFF_FFFF, 32'h3456_789A, 1'b1);
      run_single("small",  40'd17, 32'd1000, 1'b0, 4'd5, 40'd0, 32'd17, 1'b0);
      run_single("zero",   40'd0, 32'd123, 1'b0, 4'd6, 40'd0, 32'd0, 1'b0);
      run_single("max",    '1, 32'd1, 1'b0, 4'd7, '1, 32'd0, 1'b0);
      run_single("maxdsr", '1, '1, 1'b0, 4'd8, 40'd256, 32'd255, 1'b0);

      // Back-to-back stream, no backpressure.
      pops0 = pops;
      for (int i = 0; i < 100; i++) begin
         rand_op(a, d, s);
         drive(a, d, s, TAG_W'(i));
         check("stream_in_ready", 64'(bus.in_ready), 64'd1);
         tick();
      end
      idle();
      repeat (L) tick();
      check("stream_count", 64'(pops - pops0), 64'd100);
      drain("stream");

      // Fill the pipeline against a blocked sink, hold, then release.
      bus.out_ready = 1'b0;
      pops0   = pops;
      pushes0 = pushes;
      for (int i = 0; i < L + 2; i++) begin
         rand_op(a, d, s);
         drive(a, d, s, TAG_W'(i));
         tick();
      end
      for (int i = 0; i < 7; i++) begin
         rand_op(a, d, s);
         drive(a, d, s, TAG_W'(i));
         #1;
         check("stall_in_ready",  64'(bus.in_ready),  64'd0);
         check("stall_out_valid", 64'(bus.out_valid), 64'd1);
         tick();
      end
      idle();
      bus.out_ready = 1'b1;
      drain("stall");
      check("stall_accepted",     64'(pushes - pushes0), 64'(L));
      check("stall_conservation", 64'(pops - pops0),     64'(pushes - pushes0));

      // Reset with operations in flight: none may emerge.
      pops0 = pops;
      for (int i = 0; i < 5; i++) begin
         rand_op(a, d, s);
         drive(a, d, s, TAG_W'(i + 10));
         tick();
      end
      idle();
      rst = 1'b1;
      #1;
      check("flush_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      rst = 1'b0;
      repeat (2 * L) tick();
      check("flush_no_ghosts", 64'(pops - pops0), 64'd0);
      run_single("d1000_7", 40'd1000, 32'd7, 1'b0, 4'hA, 40'd142, 32'd6, 1'b0);

`ifdef DIVIDER_SIGNED_EN
      run_single("s_n29_5", N'(-29), 32'd5, 1'b1, 4'd1, N'(-5), M'(-4), 1'b0);
      run_single("s_29_n5", 40'd29, M'(-5), 1'b1, 4'd2, N'(-5), 32'd4, 1'b0);
      run_single("s_ovf",   MIN_N, '1, 1'b1, 4'd3, MIN_N, 32'd0, 1'b0);
      run_single("s_div0",  N'(-29), 32'd0, 1'b1, 4'd4, '1, M'(-29), 1'b1);
`else
      run_single("u_minn",  MIN_N, '1, 1'b1, 4'd3, 40'd128, 32'd128, 1'b0);
`endif

      drain("final");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
